// File: rtl/fir_decimate_quantize.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fir_decimate_quantize
// Description : Decimates the full-precision FIR accumulator stream by DECIM,
//               rounds (round-half-up) and arithmetically shifts the kept
//               sample by SHIFT, saturates it to DATA_OUT_WIDTH and buffers it
//               in a FIFO_DEPTH-entry FIFO with a valid/ready output.
// Ports       : clk, reset_n (async, active-low)
//               data_in/in_en          : accumulator sample + strobe
//               out_data/out_valid/out_ready : quantized FIFO head handshake
//               fifo_level             : FIFO occupancy
//               overflow/clr_overflow  : sticky drop flag and its clear
//               sat_count              : saturation event counter, present
//                                        only when FIR_DECIMATE_SATCNT_EN
//                                        is defined
// Revision    : 1.0 - initial release
// ============================================================================
module fir_decimate_quantize #(
  parameter int DATA_IN_WIDTH  = 64,
  parameter int DATA_OUT_WIDTH = 16,
  parameter int SHIFT          = 31,
  parameter int DECIM          = 4,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic signed [DATA_IN_WIDTH-1:0]  data_in,
  input  logic                             in_en,
  output logic signed [DATA_OUT_WIDTH-1:0] out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
  output logic                             overflow,
`ifdef FIR_DECIMATE_SATCNT_EN
  output logic [15:0]                      sat_count,
`endif
  input  logic                             clr_overflow
);

  localparam int c_PW  = $clog2(FIFO_DEPTH);
  localparam int c_LW  = c_PW + 1;
  localparam int c_PHW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int c_W1  = DATA_IN_WIDTH + 1;
  localparam int c_DO  = DATA_OUT_WIDTH;

  // Rounding constant 2^(SHIFT-1); zero when there is no shift.
  localparam logic [c_W1-1:0] c_RND = (SHIFT > 0) ?
      ({{(c_W1-1){1'b0}}, 1'b1} << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [c_W1-1:0] c_SAT_MAX = {{(c_W1-c_DO+1){1'b0}}, {(c_DO-1){1'b1}}};
  localparam logic signed [c_W1-1:0] c_SAT_MIN = {{(c_W1-c_DO+1){1'b1}}, {(c_DO-1){1'b0}}};

  // --------------------------------------------------------------------------
  // Phase counter and keep decision
  // --------------------------------------------------------------------------
  logic [c_PHW-1:0] phase_q, phase_d;
  logic             w_keep;

  assign w_keep = in_en && (phase_q == '0);

  always_comb begin
    phase_d = phase_q;
    if (in_en) begin
      phase_d = (phase_q == c_PHW'(DECIM - 1)) ? '0 : phase_q + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: round-half-up and arithmetic shift, one guard bit of headroom
  // --------------------------------------------------------------------------
  logic signed [c_W1-1:0] w_ext, w_rnd, s1_data_d, s1_data_q;
  logic                   s1_valid_q;

  always_comb begin
    w_ext     = {data_in[DATA_IN_WIDTH-1], data_in};
    w_rnd     = w_ext + signed'(c_RND);
    s1_data_d = w_rnd >>> SHIFT;
  end

  // --------------------------------------------------------------------------
  // Stage 2: saturation to the output range
  // --------------------------------------------------------------------------
  logic signed [c_DO-1:0] s2_data_d, s2_data_q;
  logic                   s2_valid_q;
  logic                   w_sat_evt;

  always_comb begin
    w_sat_evt = 1'b0;
    s2_data_d = s1_data_q[c_DO-1:0];
    if (s1_data_q > c_SAT_MAX) begin
      s2_data_d = c_SAT_MAX[c_DO-1:0];
      w_sat_evt = 1'b1;
    end else if (s1_data_q < c_SAT_MIN) begin
      s2_data_d = c_SAT_MIN[c_DO-1:0];
      w_sat_evt = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Output FIFO
  // --------------------------------------------------------------------------
  logic signed [c_DO-1:0] mem_q [FIFO_DEPTH];
  logic [c_PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [c_LW-1:0]        level_q, level_d;
  logic signed [c_DO-1:0] out_data_q, out_data_d;
  logic                   overflow_q, overflow_d;
  logic                   w_full, w_pop, w_wr, w_drop;

  assign out_valid  = (level_q != '0);
  assign out_data   = out_data_q;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;

  always_comb begin
    w_full     = (level_q == c_LW'(FIFO_DEPTH));
    w_pop      = out_valid && out_ready;
    w_wr       = s2_valid_q && (!w_full || w_pop);
    w_drop     = s2_valid_q && w_full && !w_pop;
    wr_ptr_d   = w_wr  ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = w_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d    = level_q;
    if (w_wr && !w_pop) begin
      level_d = level_q + 1'b1;
    end else if (!w_wr && w_pop) begin
      level_d = level_q - 1'b1;
    end
    // The head is a register so out_data keeps its last value once empty.
    // When the next head slot is the one written this edge, forward it.
    out_data_d = out_data_q;
    if (level_d != '0) begin
      out_data_d = (w_wr && (wr_ptr_q == rd_ptr_d)) ? s2_data_q : mem_q[rd_ptr_d];
    end
    // A drop in the clear cycle keeps the flag set.
    overflow_d = w_drop ? 1'b1 : (clr_overflow ? 1'b0 : overflow_q);
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      mem_q[wr_ptr_q] <= s2_data_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      out_data_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      s1_valid_q <= w_keep;
      if (w_keep) begin
        s1_data_q <= s1_data_d;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q <= s2_data_d;
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      out_data_q <= out_data_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef FIR_DECIMATE_SATCNT_EN
  // --------------------------------------------------------------------------
  // Saturation event counter; an event lands on the edge its sample reaches
  // the FIFO write port.
  // --------------------------------------------------------------------------
  logic        s2_sat_q;
  logic [15:0] sat_cnt_q, sat_cnt_d;
  logic        w_cnt_evt;

  assign sat_count = sat_cnt_q;
  assign w_cnt_evt = s2_valid_q && s2_sat_q;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (clr_overflow) begin
      sat_cnt_d = {15'd0, w_cnt_evt};
    end else if (w_cnt_evt && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_d = sat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_sat_q  <= 1'b0;
      sat_cnt_q <= '0;
    end else begin
      s2_sat_q  <= s1_valid_q && w_sat_evt;
      sat_cnt_q <= sat_cnt_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fir_decimate_quantize.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fir_decimate_quantize
// Description : Self-checking bench for fir_decimate_quantize. A queue-based
//               reference model (decimation phase, arithmetic quantizer,
//               in-flight list with arrival cycles, FIFO queue) predicts the
//               outputs after every clock; directed sections check the
//               quantization, latency, overflow and reset cases by value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_decimate_quantize;

  localparam int DIN   = 64;
  localparam int DOUT  = 16;
  localparam int SHIFT = 31;
  localparam int DECIM = 4;
  localparam int DEPTH = 8;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic signed [DIN-1:0]  data_in;
  logic                   in_en;
  logic signed [DOUT-1:0] out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [3:0]             fifo_level;
  logic                   overflow;
  logic                   clr_overflow;
`ifdef FIR_DECIMATE_SATCNT_EN
  logic [15:0]            sat_count;
`endif

  fir_decimate_quantize #(
    .DATA_IN_WIDTH(DIN), .DATA_OUT_WIDTH(DOUT), .SHIFT(SHIFT),
    .DECIM(DECIM), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .in_en(in_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_level(fifo_level), .overflow(overflow),
`ifdef FIR_DECIMATE_SATCNT_EN
    .sat_count(sat_count),
`endif
    .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                     due;
    logic signed [DOUT-1:0] v;
    bit                     sat;
  } pend_t;

  int                     n_checks = 0;
  int                     n_errors = 0;
  int                     cyc      = 0;
  int                     m_phase  = 0;
  bit                     m_ovf    = 0;
  int                     m_sat    = 0;
  logic signed [DOUT-1:0] m_last   = '0;
  logic signed [DOUT-1:0] mq [$];
  pend_t                  pipe [$];
  logic signed [DOUT-1:0] got [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Quantizer straight from the arithmetic definition: floor((x + 2^(S-1)) / 2^S), clamped.
  function automatic logic signed [DOUT-1:0] quant(input logic signed [DIN-1:0] x, output bit sat);
    logic signed [DIN+1:0] v;
    v   = x;
    v   = (v + ((DIN+2)'(1) <<< (SHIFT - 1))) >>> SHIFT;
    sat = 1'b0;
    if (v > (DIN+2)'(32767)) begin
      sat = 1'b1;
      return 16'sh7FFF;
    end
    if (v < -(DIN+2)'(32768)) begin
      sat = 1'b1;
      return -16'sh8000;
    end
    return v[DOUT-1:0];
  endfunction

  task automatic model_clear();
    mq.delete();
    pipe.delete();
    m_phase = 0;
    m_ovf   = 0;
    m_sat   = 0;
    m_last  = '0;
  endtask

  task automatic check_outputs();
    chk("out_valid", out_valid, mq.size() > 0);
    chk("out_data", out_data, m_last);
    chk("fifo_level", fifo_level, mq.size());
    chk("overflow", overflow, m_ovf);
`ifdef FIR_DECIMATE_SATCNT_EN
    chk("sat_count", sat_count, m_sat);
`endif
  endtask

  // One clock: drive inputs, advance the model over the edge, then compare.
  task automatic step(input logic signed [DIN-1:0] d, input logic en, input logic rdy, input logic clr);
    bit    pop, arr, drop, s;
    pend_t w;
    data_in      = d;
    in_en        = en;
    out_ready    = rdy;
    clr_overflow = clr;
    if (out_valid && rdy) got.push_back(out_data);
    cyc++;
    pop  = (mq.size() > 0) && rdy;
    arr  = (pipe.size() > 0) && (pipe[0].due == cyc);
    drop = 0;
    w    = '{0, '0, 0};
    if (pop) void'(mq.pop_front());
    if (arr) begin
      w = pipe.pop_front();
      if (mq.size() < DEPTH) mq.push_back(w.v);
      else drop = 1;
    end
    if (drop) m_ovf = 1;
    else if (clr) m_ovf = 0;
    if (clr) m_sat = (arr && w.sat) ? 1 : 0;
    else if (arr && w.sat && m_sat != 65535) m_sat++;
    if (en && m_phase == 0) begin
      w.v   = quant(d, s);
      w.sat = s;
      w.due = cyc + 2;
      pipe.push_back(w);
    end
    if (en) m_phase = (m_phase + 1) % DECIM;
    if (mq.size() > 0) m_last = mq[0];
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  function automatic logic signed [DIN-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // One kept sample followed by DECIM-1 discarded ones.
  task automatic feed_kept(input logic signed [DIN-1:0] d, input logic rdy);
    step(d, 1'b1, rdy, 1'b0);
    for (int i = 1; i < DECIM; i++) step(rnd64(), 1'b1, rdy, 1'b0);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(rnd64(), 1'b0, rdy, 1'b0);
  endtask

  initial begin
    int                     first_valid;
    logic signed [DIN-1:0]  d;
    logic signed [DOUT-1:0] exp_v [$];

    // ---------------- reset held with random inputs ----------------
    reset_n = 1'b0; data_in = '0; in_en = 1'b0; out_ready = 1'b0; clr_overflow = 1'b0;
    model_clear();
    for (int i = 0; i < 4; i++) begin
      data_in = rnd64(); in_en = 1'($urandom()); out_ready = 1'($urandom());
      @(posedge clk); #1;
      check_outputs();
    end
    reset_n = 1'b1;

    // ---------------- decimation and latency ----------------
    got.delete();
    first_valid = -1;
    for (int k = 0; k < 12; k++) begin
      step(DIN'(k) <<< SHIFT, 1'b1, 1'b1, 1'b0);
      if (out_valid && first_valid < 0) first_valid = k + 1;
    end
    idle(4, 1'b1);
    chk("latency_first_valid", first_valid, 3);
    chk("decim_count", got.size(), 3);
    exp_v = '{16'sd0, 16'sd4, 16'sd8};
    foreach (exp_v[i]) chk("decim_value", (i < got.size()) ? got[i] : 16'sh5555, exp_v[i]);

    // ---------------- rounding ----------------
    got.delete();
    feed_kept(64'sh40000000, 1'b1);
    feed_kept(64'sh3FFFFFFF, 1'b1);
    feed_kept(-64'sh40000000, 1'b1);
    feed_kept(-64'sh40000001, 1'b1);
    idle(4, 1'b1);
    exp_v = '{16'sd1, 16'sd0, 16'sd0, -16'sd1};
    chk("round_count", got.size(), 4);
    foreach (exp_v[i]) chk("round_value", (i < got.size()) ? got[i] : 16'sh5555, exp_v[i]);

    // ---------------- saturation ----------------
    got.delete();
    feed_kept(64'sd40000 <<< SHIFT, 1'b1);
    feed_kept(-(64'sd40000 <<< SHIFT), 1'b1);
    feed_kept(64'sd32767 <<< SHIFT, 1'b1);
    idle(4, 1'b1);
    exp_v = '{16'sd32767, -16'sd32768, 16'sd32767};
    chk("sat_count_out", got.size(), 3);
    foreach (exp_v[i]) chk("sat_value", (i < got.size()) ? got[i] : 16'sh5555, exp_v[i]);
`ifdef FIR_DECIMATE_SATCNT_EN
    chk("sat_events", sat_count, 2);
`endif

    // ---------------- backpressure / overflow ----------------
    got.delete();
    for (int k = 1; k <= 9; k++) feed_kept(DIN'(k) <<< SHIFT, 1'b0);
    idle(3, 1'b0);
    chk("full_level", fifo_level, 8);
    chk("full_overflow", overflow, 1);
    idle(10, 1'b1);
    chk("drain_count", got.size(), 8);
    for (int k = 1; k <= 8; k++) chk("drain_value", (k <= got.size()) ? got[k-1] : 16'sh5555, 16'(k));
    step(rnd64(), 1'b0, 1'b1, 1'b1);
    chk("clr_overflow", overflow, 0);

    // ---------------- full with simultaneous write and pop ----------------
    for (int k = 1; k <= 8; k++) feed_kept(DIN'(k + 20) <<< SHIFT, 1'b0);
    idle(3, 1'b0);
    chk("refill_level", fifo_level, 8);
    step(64'sd50 <<< SHIFT, 1'b1, 1'b0, 1'b0);
    step(rnd64(), 1'b1, 1'b0, 1'b0);
    step(rnd64(), 1'b1, 1'b1, 1'b0);
    chk("wr_pop_level", fifo_level, 8);
    chk("wr_pop_overflow", overflow, 0);
    step(rnd64(), 1'b1, 1'b0, 1'b0);
    idle(10, 1'b1);

    // ---------------- mid-stream reset ----------------
    for (int k = 1; k <= 5; k++) feed_kept(DIN'(k) <<< SHIFT, 1'b0);
    idle(3, 1'b0);
    chk("pre_reset_level", fifo_level, 5);
    reset_n = 1'b0;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_level", fifo_level, 0);
    model_clear();
    for (int i = 0; i < 2; i++) begin
      data_in = rnd64(); in_en = 1'b1; out_ready = 1'($urandom());
      @(posedge clk); #1;
      check_outputs();
    end
    reset_n = 1'b1;
    got.delete();
    first_valid = -1;
    step(64'sd7 <<< SHIFT, 1'b1, 1'b1, 1'b0);
    for (int i = 2; i <= 8; i++) begin
      step(64'sd9 <<< SHIFT, 1'b1, 1'b1, 1'b0);
      if (out_valid && first_valid < 0) first_valid = i;
    end
    idle(4, 1'b1);
    chk("post_reset_latency", first_valid, 3);
    chk("post_reset_first", (got.size() > 0) ? got[0] : 16'sh5555, 16'sd7);

    // ---------------- randomized traffic ----------------
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 2))
        0:       d = rnd64();
        1:       d = DIN'($signed($urandom())) <<< $urandom_range(10, 24);
        default: d = (DIN'($signed(16'($urandom()))) <<< SHIFT) + DIN'($signed(32'($urandom_range(0, 2**31 - 1))));
      endcase
      step(d, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 19) == 0));
    end
    idle(12, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
